train_sequencer: RTL and testbench

Top-level training controller for the hidden/output neuron datapath. Per sample it runs a forward pass, then a backprop pass, then a weight-update/clear step. It counts samples and epochs, stops early when loss falls below a threshold, and flags a hung phase with a watchdog. It drives the neuron enables, the init-vs-backprop weight select, and the accumulator-zero strobes.

---
 rtl/train_sequencer_pkg.sv | 15 +
 rtl/train_sequencer_if.sv | 37 +++
 rtl/train_sequencer_phase_watchdog.sv | 21 ++
 rtl/train_sequencer.sv | 87 ++++++++
 tb/tb_train_sequencer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/train_sequencer_pkg.sv
// train_sequencer_pkg: shared state codes and default widths for the training controller
package train_sequencer_pkg;
    localparam int DEF_EPOCH_W = 8;
    localparam int DEF_SAMP_W  = 4;
    localparam int DEF_LOSS_W  = 23;
    localparam int DEF_TIMEOUT = 64;
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_FWD  = 3'd1;
    localparam state_t ST_BWD  = 3'd2;
    localparam state_t ST_UPD  = 3'd3;
    localparam state_t ST_CLR  = 3'd4;
    localparam state_t ST_DONE = 3'd5;
    localparam state_t ST_ERR  = 3'd6;
endpackage

// File: rtl/train_sequencer_if.sv
// train_sequencer_if: control/status bundle between the training controller and its datapath
interface train_sequencer_if
    import train_sequencer_pkg::*;
#(
    parameter int EPOCH_W = DEF_EPOCH_W,
    parameter int SAMP_W  = DEF_SAMP_W,
    parameter int LOSS_W  = DEF_LOSS_W
);
    logic               start_i;
    logic [EPOCH_W-1:0] num_epochs_i;
    logic [SAMP_W-1:0]  num_samples_i;
    logic [LOSS_W-1:0]  loss_thresh_i;
    logic               f_done_i;
    logic               b_done_i;
    logic [LOSS_W-1:0]  loss_i;
    logic               f_en_o;
    logic               b_en_o;
    logic               init_sel_o;
    logic               zero_acc_o;
    logic               wupd_o;
    logic [EPOCH_W-1:0] epoch_o;
    logic [SAMP_W-1:0]  sample_o;
    logic               busy_o;
    logic               done_o;
    logic               early_stop_o;
    logic               timeout_o;
    modport master (
        output start_i, num_epochs_i, num_samples_i, loss_thresh_i, f_done_i, b_done_i, loss_i,
        input  f_en_o, b_en_o, init_sel_o, zero_acc_o, wupd_o, epoch_o, sample_o, busy_o, done_o,
               early_stop_o, timeout_o
    );
    modport slave (
        input  start_i, num_epochs_i, num_samples_i, loss_thresh_i, f_done_i, b_done_i, loss_i,
        output f_en_o, b_en_o, init_sel_o, zero_acc_o, wupd_o, epoch_o, sample_o, busy_o, done_o,
               early_stop_o, timeout_o
    );
endinterface

// File: rtl/train_sequencer_phase_watchdog.sv
// phase_watchdog: counts enabled cycles since the last clear and flags the final allowed cycle
module phase_watchdog
    import train_sequencer_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int CNT_W = TIMEOUT > 2 ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] r_cnt;
    assign o_expire = i_en && r_cnt == CNT_W'(TIMEOUT - 1);
    // count enabled cycles, holding at the expiry value until cleared
    always_ff @(posedge clk_i) begin
        if (rst_i || i_clr) r_cnt <= '0;
        else if (i_en && !o_expire) r_cnt <= r_cnt + CNT_W'(1);
    end
endmodule

// File: rtl/train_sequencer.sv
// train_sequencer: sequences forward, backprop and update/clear per sample with early stop and watchdog
module train_sequencer
    import train_sequencer_pkg::*;
#(
    parameter int EPOCH_W = DEF_EPOCH_W,
    parameter int SAMP_W  = DEF_SAMP_W,
    parameter int LOSS_W  = DEF_LOSS_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic clk_i,
    input logic rst_i,
    train_sequencer_if.slave bus
);
    state_t             r_state, w_next;
    logic [EPOCH_W-1:0] r_epoch, r_ne, w_ep_inc;
    logic [SAMP_W-1:0]  r_sample, r_ns;
    logic [LOSS_W-1:0]  r_th;
    logic               r_early, r_init;
    logic               w_idle, w_start, w_zero, w_lt, w_last, w_exp, w_clr, w_wd_en;
    assign w_idle   = r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERR;
    assign w_start  = w_idle && bus.start_i;
    assign w_zero   = bus.num_epochs_i == '0 || bus.num_samples_i == '0;
    assign w_lt     = bus.loss_i < r_th;
    assign w_last   = r_sample == r_ns - SAMP_W'(1);
    assign w_ep_inc = r_epoch + EPOCH_W'(1);
    assign w_wd_en  = r_state == ST_FWD || r_state == ST_BWD;
    assign w_clr    = w_next != r_state;
    phase_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_clr    (w_clr),
        .i_en     (w_wd_en),
        .o_expire (w_exp)
    );
    // next phase: completion beats a same-cycle watchdog expiry; idle states only react to start
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FWD:  w_next = bus.f_done_i ? (w_lt ? ST_DONE : ST_BWD) : (w_exp ? ST_ERR : ST_FWD);
            ST_BWD:  w_next = bus.b_done_i ? ST_UPD : (w_exp ? ST_ERR : ST_BWD);
            ST_UPD:  w_next = ST_CLR;
            ST_CLR:  w_next = (w_last && w_ep_inc == r_ne) ? ST_DONE : ST_FWD;
            default: w_next = bus.start_i ? (w_zero ? ST_DONE : ST_FWD) : (w_idle ? r_state : ST_IDLE);
        endcase
    end
    // state, latched limits and sample/epoch bookkeeping
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_epoch  <= '0;
            r_sample <= '0;
            r_ne     <= '0;
            r_ns     <= '0;
            r_th     <= '0;
            r_early  <= 1'b0;
            r_init   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_ne     <= bus.num_epochs_i;
                r_ns     <= bus.num_samples_i;
                r_th     <= bus.loss_thresh_i;
                r_epoch  <= '0;
                r_sample <= '0;
                r_early  <= 1'b0;
                r_init   <= 1'b1;
            end
            if (r_state == ST_FWD && bus.f_done_i && w_lt) r_early <= 1'b1;
            if (r_state == ST_UPD) r_init <= 1'b0;
            if (r_state == ST_CLR) begin
                r_sample <= w_last ? '0 : r_sample + SAMP_W'(1);
                if (w_last) r_epoch <= w_ep_inc;
            end
        end
    end
    assign bus.f_en_o       = r_state == ST_FWD;
    assign bus.b_en_o       = r_state == ST_BWD;
    assign bus.init_sel_o   = r_state == ST_FWD && r_init;
    assign bus.wupd_o       = r_state == ST_UPD;
    assign bus.zero_acc_o   = r_state == ST_CLR;
    assign bus.busy_o       = !w_idle;
    assign bus.done_o       = r_state == ST_DONE;
    assign bus.timeout_o    = r_state == ST_ERR;
    assign bus.early_stop_o = r_early;
    assign bus.epoch_o      = r_epoch;
    assign bus.sample_o     = r_sample;
endmodule

// File: tb/tb_train_sequencer.sv
// tb_train_sequencer: randomized scoreboard bench for the training controller
module tb_train_sequencer;
    import train_sequencer_pkg::*;
    localparam int T = 10;
    localparam int BUDGET = 20000;
    localparam int K_WUPD = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;
    typedef struct {
        int k;
        int ep;
        int sp;
        int early;
        int passes;
        int ph;
    } ev_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rsp_f = 1'b0, rsp_b = 1'b0, man_b = 1'b0;
    logic [DEF_LOSS_W-1:0] rsp_loss = '0;
    int vecs = 0, errs = 0;
    int m_thresh = 0, fixed_d = 0;
    bit hang_f = 0, hang_b = 0;
    int loss_plan[$];
    ev_t sb[$];
    always #(T/2) clk = ~clk;
    train_sequencer_if #(.EPOCH_W(DEF_EPOCH_W), .SAMP_W(DEF_SAMP_W), .LOSS_W(DEF_LOSS_W)) bus ();
    train_sequencer #(
        .EPOCH_W (DEF_EPOCH_W),
        .SAMP_W  (DEF_SAMP_W),
        .LOSS_W  (DEF_LOSS_W),
        .TIMEOUT (DEF_TIMEOUT)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );
    assign bus.f_done_i = rsp_f;
    assign bus.b_done_i = rsp_b | man_b;
    assign bus.loss_i   = rsp_loss;
    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endfunction
    function automatic void push(input int k, ep, sp, early, passes, ph);
        ev_t ev;
        ev.k = k; ev.ep = ep; ev.sp = sp; ev.early = early; ev.passes = passes; ev.ph = ph;
        sb.push_back(ev);
    endfunction
    function automatic bit pop(output ev_t ev);
        chk("sb_has_expected_event", sb.size() > 0, 1);
        if (sb.size() == 0) return 0;
        ev = sb.pop_front();
        return 1;
    endfunction
    function automatic logic [63:0] outs();
        return 64'({bus.f_en_o, bus.b_en_o, bus.init_sel_o, bus.zero_acc_o, bus.wupd_o, bus.epoch_o,
                    bus.sample_o, bus.busy_o, bus.done_o, bus.early_stop_o, bus.timeout_o});
    endfunction
    function automatic int pick();
        return fixed_d != 0 ? fixed_d : int'($urandom_range(1, 8));
    endfunction
    // datapath stand-in: answers each enable after a (random or fixed) number of cycles
    initial begin : responder
        int fc = 0, bc = 0, fd, bd;
        fd = pick();
        bd = pick();
        forever begin
            @(posedge clk);
            #1;
            rsp_f = 1'b0;
            rsp_b = 1'b0;
            if (bus.f_en_o && !hang_f) begin
                fc++;
                if (fc >= fd) begin
                    rsp_f = 1'b1;
                    rsp_loss = loss_plan.size() > 0 ? DEF_LOSS_W'(loss_plan.pop_front()) : '0;
                    fc = 0;
                    fd = pick();
                end
            end else fc = 0;
            if (bus.b_en_o && !hang_b) begin
                bc++;
                if (bc >= bd) begin
                    rsp_b = 1'b1;
                    bc = 0;
                    bd = pick();
                end
            end else bc = 0;
        end
    end
    // monitor: latency rules every cycle, scoreboard pops on weight updates and on run end
    initial begin : monitor
        ev_t ev;
        int run_f = 0, run_b = 0, last_f = 0, last_b = 0, fen_rises = 0, wupd_seen = 0;
        bit armed = 0, pv_fen = 0, pv_fd = 0, pv_lt = 0, pv_bd = 0, pv_wupd = 0, pv_zero = 0, pv_rst = 1;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                armed = 0;
            end else if (!pv_rst) begin
                if (pv_fd) chk("fwd_done_next_state", {bus.b_en_o, bus.done_o}, pv_lt ? 1 : 2);
                if (pv_bd) chk("bwd_done_to_wupd", bus.wupd_o, 1);
                if (pv_wupd) chk("wupd_to_zero_acc", bus.zero_acc_o, 1);
                if (pv_zero) chk("zero_acc_to_next", bus.f_en_o | bus.done_o, 1);
                chk("init_sel", bus.init_sel_o, armed && bus.f_en_o && wupd_seen == 0);
            end
            if (bus.f_en_o) run_f++;
            else if (run_f != 0) begin
                last_f = run_f;
                run_f = 0;
            end
            if (bus.b_en_o) run_b++;
            else if (run_b != 0) begin
                last_b = run_b;
                run_b = 0;
            end
            if (!rst && bus.f_en_o && !pv_fen) fen_rises++;
            if (!rst && bus.wupd_o) begin
                wupd_seen++;
                if (pop(ev)) begin
                    chk("wupd_kind", K_WUPD, ev.k);
                    chk("wupd_epoch", bus.epoch_o, ev.ep);
                    chk("wupd_sample", bus.sample_o, ev.sp);
                end
            end
            if (!rst && armed && (bus.done_o || bus.timeout_o)) begin
                armed = 0;
                if (pop(ev)) begin
                    chk("end_kind", bus.timeout_o ? K_ERR : K_DONE, ev.k);
                    chk("end_epoch", bus.epoch_o, ev.ep);
                    chk("end_sample", bus.sample_o, ev.sp);
                    chk("end_early_stop", bus.early_stop_o, ev.early);
                    chk("end_fwd_passes", fen_rises, ev.passes);
                    if (ev.k == K_ERR) begin
                        chk("err_phase_cycles", ev.ph != 0 ? last_b : last_f, DEF_TIMEOUT);
                        chk("err_outputs_idle", {bus.f_en_o, bus.b_en_o, bus.busy_o}, 0);
                    end
                end
            end
            if (!rst && bus.start_i && !bus.busy_o) begin
                armed = 1;
                wupd_seen = 0;
                fen_rises = 0;
            end
            pv_fen  = bus.f_en_o;
            pv_fd   = bus.f_en_o && bus.f_done_i;
            pv_lt   = bus.loss_i < m_thresh;
            pv_bd   = bus.b_en_o && bus.b_done_i;
            pv_wupd = bus.wupd_o;
            pv_zero = bus.zero_acc_o;
            pv_rst  = rst;
        end
    end
    // one training run: build the expected event list from the rules, start, optionally poke, wait
    task automatic run(input int e, s, th, input bit hf, hb, spur, preset);
        int passes = 0, n = 0;
        bit fin = 0;
        int lp[$];
        if (!preset) begin
            loss_plan.delete();
            repeat (e * s) loss_plan.push_back(int'($urandom_range(0, 200)));
        end
        lp = loss_plan;
        m_thresh = th;
        hang_f = hf;
        hang_b = hb;
        if (e == 0 || s == 0) push(K_DONE, 0, 0, 0, 0, 0);
        else if (hf) push(K_ERR, 0, 0, 0, 1, 0);
        else begin
            for (int ep = 0; ep < e && !fin; ep++)
                for (int sp = 0; sp < s && !fin; sp++) begin
                    passes++;
                    if (lp[ep * s + sp] < th) begin
                        push(K_DONE, ep, sp, 1, passes, 0);
                        fin = 1;
                    end else if (hb) begin
                        push(K_ERR, ep, sp, 0, passes, 1);
                        fin = 1;
                    end else push(K_WUPD, ep, sp, 0, 0, 0);
                end
            if (!fin) push(K_DONE, e, 0, 0, passes, 0);
        end
        @(posedge clk);
        #1;
        bus.num_epochs_i  = DEF_EPOCH_W'(e);
        bus.num_samples_i = DEF_SAMP_W'(s);
        bus.loss_thresh_i = DEF_LOSS_W'(th);
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        if (e == 0 || s == 0) chk("zero_limit_done_next", {bus.done_o, bus.busy_o, bus.f_en_o}, 4);
        if (spur) begin
            chk("spurious_in_fwd", bus.f_en_o, 1);
            bus.start_i = 1'b1;
            man_b = 1'b1;
            bus.num_epochs_i  = 1;
            bus.num_samples_i = 1;
            bus.loss_thresh_i = '1;
            @(posedge clk);
            #1;
            bus.start_i = 1'b0;
            man_b = 1'b0;
            chk("spurious_no_change", {bus.f_en_o, bus.b_en_o}, 2);
        end
        while (n < BUDGET && (bus.busy_o || !(bus.done_o || bus.timeout_o))) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("run_finishes", n < BUDGET, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        hang_f = 0;
        hang_b = 0;
    endtask
    initial begin : stimulus
        int n = 0;
        bus.start_i = 1'b0;
        bus.num_epochs_i = '0;
        bus.num_samples_i = '0;
        bus.loss_thresh_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", outs(), 0);
        rst = 1'b0;
        loss_plan.delete();
        repeat (6) loss_plan.push_back(100);
        fixed_d = 5;
        run(2, 3, 0, 0, 0, 0, 1);
        fixed_d = 0;
        chk("nominal_final", {bus.epoch_o, bus.done_o, bus.early_stop_o}, {8'd2, 2'b10});
        loss_plan = '{80, 30};
        run(4, 2, 50, 0, 0, 0, 1);
        chk("early_final", {bus.epoch_o, bus.sample_o, bus.early_stop_o}, {8'd0, 4'd1, 1'b1});
        run(3, 2, 20, 1, 0, 0, 0);
        chk("timeout_final", {bus.timeout_o, bus.f_en_o}, 2);
        run(2, 2, 10, 0, 0, 0, 0);
        run(1, 1, 0, 0, 1, 0, 0);
        run(0, 3, 5, 0, 0, 0, 0);
        run(2, 0, 5, 0, 0, 0, 0);
        loss_plan.delete();
        repeat (4) loss_plan.push_back(100);
        m_thresh = 0;
        @(posedge clk);
        #1;
        bus.num_epochs_i = 2;
        bus.num_samples_i = 2;
        bus.loss_thresh_i = '0;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        while (n < 200 && !bus.b_en_o) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reached_bwd", bus.b_en_o, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_mid_bwd", outs(), 0);
        rst = 1'b0;
        man_b = 1'b1;
        @(posedge clk);
        #1;
        man_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("b_done_after_reset_ignored", outs(), 0);
        loss_plan.delete();
        repeat (6) loss_plan.push_back(100);
        fixed_d = 5;
        run(2, 3, 0, 0, 0, 1, 1);
        fixed_d = 0;
        chk("spurious_final", {bus.epoch_o, bus.done_o, bus.early_stop_o}, {8'd2, 2'b10});
        repeat (25) run(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), int'($urandom_range(0, 40)), 0, 0, 0, 0);
        run(255, 1, 0, 0, 0, 0, 0);
        chk("max_epochs_final", {bus.epoch_o, bus.done_o}, {8'd255, 1'b1});
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
    initial begin : global_bound
        #(T * 90000);
        $display("FAIL global_bound: simulation still running, want finished");
        $fatal(1, "simulation bound expired");
    end
endmodule
